// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for lsu_ctrl: RV32I load/store funct3 codes, data_mem size/sign encoding,
// controller FSM states and the decode helpers.
package lsu_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef enum logic [0:0] {
        StRun,
        StTrap
    } lsu_state_e;

    // Bit 2 is sign-extend; funct3 values with no RV32I meaning fall back to word size.
    function automatic logic [2:0] funct3_to_sign_mask(input logic [2:0] funct3);
        logic [1:0] size;
        unique case (funct3[1:0])
            2'b00:   size = SZ_BYTE;
            2'b01:   size = SZ_HALF;
            default: size = SZ_WORD;
        endcase
        return {~funct3[2], size};
    endfunction

    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        logic mis;
        unique case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_resp_fifo.sv
// Synchronous power-of-two FIFO holding returned load data until writeback takes it.
module lsu_resp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 37
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic                     empty_o,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW:0]      count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A pop frees the head slot in the same edge, so a full FIFO can still take a push.
    assign do_push = push_i & (~full | do_pop);
    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
            end
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) push_i |-> (!full || pop_i))
        else $error("lsu_resp_fifo overflow: push while full");

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage between EX and data_mem: one-cycle issue, credit-tracked loads,
// misalignment trap. Defining LSU_STATS_EN adds load/store/stall counters.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned RESP_DEPTH = 4,
    parameter int unsigned REG_W      = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_is_load_i,
    input  logic             req_is_store_i,
    input  logic [31:0]      req_addr_i,
    input  logic [31:0]      req_wdata_i,
    input  logic [2:0]       req_funct3_i,
    input  logic [REG_W-1:0] req_rd_i,
    input  logic             kill_i,
    output logic [31:0]      dmem_addr_o,
    output logic [31:0]      dmem_wdata_o,
    output logic             dmem_w_ena_o,
    output logic             dmem_r_ena_o,
    output logic [2:0]       dmem_sign_mask_o,
    input  logic [31:0]      dmem_rdata_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [REG_W-1:0] wb_rd_o,
    output logic [31:0]      wb_data_o,
    output logic             misalign_o,
    output logic [31:0]      misalign_addr_o,
    input  logic             trap_ack_i
`ifdef LSU_STATS_EN
    ,
    output logic [31:0]      stat_loads_o,
    output logic [31:0]      stat_stores_o,
    output logic [31:0]      stat_stall_o
`endif
);
    localparam int unsigned CW = $clog2(RESP_DEPTH) + 1;
    localparam int unsigned FW = REG_W + 32;

    lsu_state_e state_q, state_d;

    logic             iss_valid_q, iss_valid_d;
    logic             iss_load_q;
    logic [31:0]      iss_addr_q;
    logic [31:0]      iss_wdata_q;
    logic [2:0]       iss_mask_q;
    logic [REG_W-1:0] iss_rd_q;

    logic             resp_valid_q;
    logic [REG_W-1:0] resp_rd_q;
    logic [31:0]      misalign_addr_q;

    logic [2:0]       req_mask;
    logic             req_fire;
    logic             misalign_now;
    logic [CW:0]      credits_used;
    logic             fifo_push;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_cnt;
    logic [FW-1:0]    fifo_head;

    assign req_mask = funct3_to_sign_mask(req_funct3_i);

    // Every load from issue through FIFO holds one credit, so data_mem can never outrun the FIFO.
    assign credits_used = {1'b0, fifo_cnt}
                        + (CW + 1)'(iss_valid_q & iss_load_q)
                        + (CW + 1)'(resp_valid_q);

    assign req_ready_o = rst_ni && (state_q == StRun)
                         && (credits_used < (CW + 1)'(RESP_DEPTH));

    assign req_fire     = req_valid_i & req_ready_o & (req_is_load_i | req_is_store_i) & ~kill_i;
    assign misalign_now = req_fire & is_misaligned(req_addr_i[1:0], req_mask[1:0]);
    assign iss_valid_d  = req_fire & ~misalign_now;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            iss_valid_q <= 1'b0;
            iss_load_q  <= 1'b0;
            iss_addr_q  <= '0;
            iss_wdata_q <= '0;
            iss_mask_q  <= '0;
            iss_rd_q    <= '0;
        end else begin
            iss_valid_q <= iss_valid_d;
            if (iss_valid_d) begin
                iss_load_q  <= req_is_load_i;
                iss_addr_q  <= req_addr_i;
                iss_wdata_q <= req_wdata_i;
                iss_mask_q  <= req_mask;
                iss_rd_q    <= req_rd_i;
            end
        end
    end

    // A flush in the issue cycle must stop the access before data_mem sees it.
    assign dmem_r_ena_o     = iss_valid_q & iss_load_q & ~kill_i;
    assign dmem_w_ena_o     = iss_valid_q & ~iss_load_q & ~kill_i;
    assign dmem_addr_o      = iss_addr_q;
    assign dmem_wdata_o     = iss_wdata_q;
    assign dmem_sign_mask_o = iss_mask_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_q <= 1'b0;
            resp_rd_q    <= '0;
        end else begin
            resp_valid_q <= dmem_r_ena_o;
            if (dmem_r_ena_o) begin
                resp_rd_q <= iss_rd_q;
            end
        end
    end

    // Response data is only valid this cycle, so a flush now is the killed case.
    assign fifo_push = resp_valid_q & ~kill_i;

    lsu_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (FW)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .wdata_i ({resp_rd_q, dmem_rdata_i}),
        .pop_i   (wb_ready_i),
        .empty_o (fifo_empty),
        .rdata_o (fifo_head),
        .count_o (fifo_cnt)
    );

    assign wb_valid_o = ~fifo_empty;
    assign wb_rd_o    = fifo_head[FW-1:32];
    assign wb_data_o  = fifo_head[31:0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (misalign_now) begin
                    state_d = StTrap;
                end
            end
            StTrap: begin
                if (trap_ack_i || kill_i) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= StRun;
            misalign_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (misalign_now) begin
                misalign_addr_q <= req_addr_i;
            end
        end
    end

    assign misalign_o      = (state_q == StTrap);
    assign misalign_addr_o = misalign_addr_q;

`ifdef LSU_STATS_EN
    logic [31:0] stat_loads_q;
    logic [31:0] stat_stores_q;
    logic [31:0] stat_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_loads_q  <= '0;
            stat_stores_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (dmem_r_ena_o) begin
                stat_loads_q <= stat_loads_q + 32'd1;
            end
            if (dmem_w_ena_o) begin
                stat_stores_q <= stat_stores_q + 32'd1;
            end
            if (req_valid_i && !req_ready_o) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_loads_o  = stat_loads_q;
    assign stat_stores_o = stat_stores_q;
    assign stat_stall_o  = stat_stall_q;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a small byte-addressed data_mem model (1-cycle read latency).
module tb_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_is_load, req_is_store;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    logic        kill;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_w_ena, dmem_r_ena;
    logic [2:0]  dmem_mask;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign;
    logic [31:0] misalign_addr;
    logic        trap_ack;
`ifdef LSU_STATS_EN
    logic [31:0] stat_loads, stat_stores, stat_stall;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(
        .RESP_DEPTH (4),
        .REG_W      (5)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_is_load_i    (req_is_load),
        .req_is_store_i   (req_is_store),
        .req_addr_i       (req_addr),
        .req_wdata_i      (req_wdata),
        .req_funct3_i     (req_funct3),
        .req_rd_i         (req_rd),
        .kill_i           (kill),
        .dmem_addr_o      (dmem_addr),
        .dmem_wdata_o     (dmem_wdata),
        .dmem_w_ena_o     (dmem_w_ena),
        .dmem_r_ena_o     (dmem_r_ena),
        .dmem_sign_mask_o (dmem_mask),
        .dmem_rdata_i     (dmem_rdata),
        .wb_valid_o       (wb_valid),
        .wb_ready_i       (wb_ready),
        .wb_rd_o          (wb_rd),
        .wb_data_o        (wb_data),
        .misalign_o       (misalign),
        .misalign_addr_o  (misalign_addr),
        .trap_ack_i       (trap_ack)
`ifdef LSU_STATS_EN
        ,
        .stat_loads_o     (stat_loads),
        .stat_stores_o    (stat_stores),
        .stat_stall_o     (stat_stall)
`endif
    );

    // data_mem model: preloaded while in reset, writes on w_ena, registered read on r_ena.
    logic [7:0] mem [512];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
            for (int i = 0; i < 6; i++) begin
                mem[9'(4 * i)]     <= 8'(i);
                mem[9'(4 * i + 2)] <= 8'h11;
                mem[9'(4 * i + 3)] <= 8'h11;
            end
            mem[9'h100] <= 8'hEF; mem[9'h101] <= 8'hBE; mem[9'h102] <= 8'hAD; mem[9'h103] <= 8'hDE;
            mem[9'h040] <= 8'h67; mem[9'h041] <= 8'h45; mem[9'h042] <= 8'h23; mem[9'h043] <= 8'h01;
            dmem_rdata <= 32'h0;
        end else begin
            if (dmem_w_ena) begin
                mem[dmem_addr[8:0]] <= dmem_wdata[7:0];
                if (dmem_mask[1:0] != 2'b00) mem[dmem_addr[8:0] + 9'd1] <= dmem_wdata[15:8];
                if (dmem_mask[1:0] == 2'b11) begin
                    mem[dmem_addr[8:0] + 9'd2] <= dmem_wdata[23:16];
                    mem[dmem_addr[8:0] + 9'd3] <= dmem_wdata[31:24];
                end
            end
            if (dmem_r_ena) begin
                case (dmem_mask[1:0])
                    2'b00: dmem_rdata <= {{24{dmem_mask[2] & mem[dmem_addr[8:0]][7]}},
                                          mem[dmem_addr[8:0]]};
                    2'b01: dmem_rdata <= {{16{dmem_mask[2] & mem[dmem_addr[8:0] + 9'd1][7]}},
                                          mem[dmem_addr[8:0] + 9'd1], mem[dmem_addr[8:0]]};
                    default: dmem_rdata <= {mem[dmem_addr[8:0] + 9'd3], mem[dmem_addr[8:0] + 9'd2],
                                            mem[dmem_addr[8:0] + 9'd1], mem[dmem_addr[8:0]]};
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid    = 1'b0;
        req_is_load  = 1'b0;
        req_is_store = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_funct3   = 3'b000;
        req_rd       = 5'd0;
    endtask

    task automatic set_req(input logic ld, input logic st, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] f3, input logic [4:0] rd);
        req_valid    = 1'b1;
        req_is_load  = ld;
        req_is_store = st;
        req_addr     = addr;
        req_wdata    = wdata;
        req_funct3   = f3;
        req_rd       = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n_acc, n_pop;
        logic acc_now, seen_wb;

        rst_n = 1'b0; kill = 1'b0; trap_ack = 1'b0; wb_ready = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_enables", 32'({dmem_r_ena, dmem_w_ena}), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        rst_n = 1'b1;
        nxt();
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // LW x5, 0x100
        set_req(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 5'd5);
        @(negedge clk); chk("lw_ready", 32'(req_ready), 32'd1);
        nxt(); idle();
        @(negedge clk);
        chk("lw_r_ena_t1", 32'(dmem_r_ena), 32'd1);
        chk("lw_w_ena_t1", 32'(dmem_w_ena), 32'd0);
        chk("lw_addr_t1", dmem_addr, 32'h100);
        chk("lw_mask_t1", 32'(dmem_mask), 32'd7);
        nxt(); @(negedge clk);
        chk("lw_r_ena_t2", 32'(dmem_r_ena), 32'd0);
        chk("lw_wb_valid_t2", 32'(wb_valid), 32'd0);
        nxt(); @(negedge clk);
        chk("lw_wb_valid_t3", 32'(wb_valid), 32'd1);
        chk("lw_wb_rd", 32'(wb_rd), 32'd5);
        chk("lw_wb_data", wb_data, 32'hDEADBEEF);
        nxt(); @(negedge clk);
        chk("lw_wb_popped", 32'(wb_valid), 32'd0);

        // SB 0x80 -> 0x101 then LBU x7, 0x101 back to back
        nxt();
        set_req(1'b0, 1'b1, 32'h101, 32'h12345680, 3'b000, 5'd0);
        @(negedge clk); nxt();
        set_req(1'b1, 1'b0, 32'h101, 32'h0, 3'b100, 5'd7);
        @(negedge clk);
        chk("sb_w_ena", 32'(dmem_w_ena), 32'd1);
        chk("sb_r_ena", 32'(dmem_r_ena), 32'd0);
        chk("sb_addr", dmem_addr, 32'h101);
        chk("sb_mask", 32'(dmem_mask), 32'd4);
        chk("sb_wdata", dmem_wdata, 32'h12345680);
        nxt(); idle();
        @(negedge clk);
        chk("lbu_r_ena", 32'(dmem_r_ena), 32'd1);
        chk("lbu_w_ena", 32'(dmem_w_ena), 32'd0);
        chk("lbu_mask", 32'(dmem_mask), 32'd0);
        nxt(); @(negedge clk); nxt(); @(negedge clk);
        chk("lbu_wb_valid", 32'(wb_valid), 32'd1);
        chk("lbu_wb_rd", 32'(wb_rd), 32'd7);
        chk("lbu_wb_data", wb_data, 32'h00000080);

        // LB x8, 0x101
        nxt();
        set_req(1'b1, 1'b0, 32'h101, 32'h0, 3'b000, 5'd8);
        @(negedge clk); nxt(); idle();
        @(negedge clk); chk("lb_mask", 32'(dmem_mask), 32'd4);
        nxt(); @(negedge clk); nxt(); @(negedge clk);
        chk("lb_wb_valid", 32'(wb_valid), 32'd1);
        chk("lb_wb_data", wb_data, 32'hFFFFFF80);

        // LH at 0x103 traps; released by trap_ack
        nxt();
        set_req(1'b1, 1'b0, 32'h103, 32'h0, 3'b001, 5'd9);
        @(negedge clk); chk("lh_mis_ready", 32'(req_ready), 32'd1);
        nxt(); idle();
        @(negedge clk);
        chk("lh_mis_enables", 32'({dmem_r_ena, dmem_w_ena}), 32'd0);
        chk("lh_mis_flag", 32'(misalign), 32'd1);
        chk("lh_mis_addr", misalign_addr, 32'h103);
        chk("lh_mis_ready_t1", 32'(req_ready), 32'd0);
        nxt(); @(negedge clk);
        chk("lh_mis_hold", 32'({misalign, req_ready}), 32'b10);
        nxt(); trap_ack = 1'b1;
        @(negedge clk); nxt(); trap_ack = 1'b0;
        @(negedge clk);
        chk("trap_ack_clear", 32'({misalign, req_ready}), 32'b01);

        // LW at 0x102 traps; kill clears the trap
        nxt();
        set_req(1'b1, 1'b0, 32'h102, 32'h0, 3'b010, 5'd9);
        @(negedge clk); nxt(); idle();
        @(negedge clk); chk("lw_mis_flag", 32'(misalign), 32'd1);
        nxt(); kill = 1'b1;
        @(negedge clk); nxt(); kill = 1'b0;
        @(negedge clk);
        chk("kill_clears_trap", 32'({misalign, req_ready}), 32'b01);

        // Six back-to-back loads against a stalled writeback
        nxt();
        wb_ready = 1'b0;
        n_acc = 0; n_pop = 0;
        for (int c = 0; c < 8; c++) begin
            if (n_acc < 6) set_req(1'b1, 1'b0, 32'(4 * n_acc), 32'h0, 3'b010, 5'(10 + n_acc));
            else idle();
            @(negedge clk); acc_now = req_ready;
            nxt();
            if (acc_now && n_acc < 6) n_acc++;
        end
        @(negedge clk);
        chk("credit_accepts", 32'(n_acc), 32'd4);
        chk("credit_ready_low", 32'(req_ready), 32'd0);
        chk("credit_head_valid", 32'(wb_valid), 32'd1);
        chk("credit_head_rd", 32'(wb_rd), 32'd10);
        chk("credit_head_data", wb_data, 32'h11110000);
        nxt();
        wb_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (n_acc < 6) set_req(1'b1, 1'b0, 32'(4 * n_acc), 32'h0, 3'b010, 5'(10 + n_acc));
            else idle();
            @(negedge clk);
            acc_now = req_ready;
            if (wb_valid) begin
                chk("order_data", wb_data, 32'h11110000 + 32'(n_pop));
                chk("order_rd", 32'(wb_rd), 32'(10 + n_pop));
                n_pop++;
            end
            nxt();
            if (acc_now && n_acc < 6) n_acc++;
        end
        idle();
        chk("credit_total_acc", 32'(n_acc), 32'd6);
        chk("credit_total_pop", 32'(n_pop), 32'd6);

        // SW killed in its issue cycle; memory must keep 0x01234567
        set_req(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 3'b010, 5'd0);
        @(negedge clk); nxt(); idle(); kill = 1'b1;
        @(negedge clk);
        chk("kill_store_w_ena", 32'(dmem_w_ena), 32'd0);
        nxt(); kill = 1'b0;
        set_req(1'b1, 1'b0, 32'h40, 32'h0, 3'b010, 5'd3);
        @(negedge clk); nxt(); idle();
        @(negedge clk); nxt(); @(negedge clk); nxt(); @(negedge clk);
        chk("kill_store_mem_valid", 32'(wb_valid), 32'd1);
        chk("kill_store_mem_data", wb_data, 32'h01234567);

        // Request alongside kill is not accepted
        nxt();
        set_req(1'b1, 1'b0, 32'h40, 32'h0, 3'b010, 5'd3); kill = 1'b1;
        @(negedge clk); nxt(); idle(); kill = 1'b0;
        @(negedge clk);
        chk("kill_same_cycle_r_ena", 32'(dmem_r_ena), 32'd0);

        // Load killed in its response cycle never reaches writeback
        nxt();
        set_req(1'b1, 1'b0, 32'h40, 32'h0, 3'b010, 5'd4);
        @(negedge clk); nxt(); idle();
        @(negedge clk); chk("kill_load_r_ena", 32'(dmem_r_ena), 32'd1);
        nxt(); kill = 1'b1;
        @(negedge clk); nxt(); kill = 1'b0;
        seen_wb = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); seen_wb = seen_wb | wb_valid;
            nxt();
        end
        chk("kill_load_no_wb", 32'(seen_wb), 32'd0);

        // Reset asserted in the issue cycle of a load
        set_req(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 5'd9);
        @(negedge clk); nxt(); idle();
        @(negedge clk);
        chk("rst_mid_r_ena_before", 32'(dmem_r_ena), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_enables", 32'({dmem_r_ena, dmem_w_ena}), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd0);
        chk("rst_mid_addr", dmem_addr, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        seen_wb = 1'b0;
        for (int c = 0; c < 5; c++) begin
            nxt(); @(negedge clk);
            seen_wb = seen_wb | wb_valid | dmem_r_ena | dmem_w_ena;
        end
        chk("rst_mid_quiet", 32'(seen_wb), 32'd0);
        chk("rst_mid_ready_back", 32'(req_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
